// File: rtl/draw_arbiter.sv
// Round-robin owner of the VGA pixel port: latches one requester's box and rasters it XDIM x YDIM, one pixel/clk.
// Grant one cycle after req is seen in IDLE, done 2+XDIM*YDIM cycles after; define DRAW_ARBITER_CLIP_EN to drop off-screen plots.
module draw_arbiter #(
   parameter int NREQ    = 4,
   parameter int XDIM    = 10,
   parameter int YDIM    = 10,
   parameter int XSCREEN = 160,
   parameter int YSCREEN = 120
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [8*NREQ-1:0]   req_x,
   input  logic [7*NREQ-1:0]   req_y,
   input  logic [3*NREQ-1:0]   req_colour,
   output logic [NREQ-1:0]     grant,
   output logic [NREQ-1:0]     done,
   output logic [7:0]          vga_x,
   output logic [6:0]          vga_y,
   output logic [2:0]          vga_colour,
   output logic                plot,
   output logic                busy
);

   localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int XW = (XDIM > 1) ? $clog2(XDIM) : 1;
   localparam int YW = (YDIM > 1) ? $clog2(YDIM) : 1;

   typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} state_t;

   state_t          state, state_nx;
   logic [WW-1:0]   ptr, winner, pick;
   logic            pick_vld;
   logic [7:0]      ox, hold_x, pix_x;
   logic [6:0]      oy, hold_y, pix_y;
   logic [2:0]      col, hold_c;
   logic [XW-1:0]   xc;
   logic [YW-1:0]   yc;
   logic            x_last, y_last, in_screen;
   logic [NREQ-1:0] owner_oh;

   // First set request at or above the pointer, wrapping; lowest offset is evaluated last so it wins.
   always_comb begin
      int idx;
      idx      = 0;
      pick     = ptr;
      pick_vld = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[idx]) begin
            pick     = WW'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   assign x_last = (xc == XW'(XDIM - 1));
   assign y_last = (yc == YW'(YDIM - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (pick_vld) state_nx = LATCH;
         LATCH:   state_nx = DRAW;
         DRAW:    if (x_last && y_last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr    <= '0;
         winner <= '0;
         ox     <= '0;
         oy     <= '0;
         col    <= '0;
         xc     <= '0;
         yc     <= '0;
         hold_x <= '0;
         hold_y <= '0;
         hold_c <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) winner <= pick;
            end
            LATCH: begin
               ox  <= req_x[8*int'(winner) +: 8];
               oy  <= req_y[7*int'(winner) +: 7];
               col <= req_colour[3*int'(winner) +: 3];
               xc  <= '0;
               yc  <= '0;
            end
            DRAW: begin
               hold_x <= pix_x;
               hold_y <= pix_y;
               hold_c <= col;
               if (!x_last) begin
                  xc <= xc + XW'(1);
               end else begin
                  xc <= '0;
                  if (!y_last) yc <= yc + YW'(1);
               end
            end
            DONE: begin
               ptr <= (winner == WW'(NREQ - 1)) ? '0 : winner + WW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef DRAW_ARBITER_CLIP_EN
   // Wide sums so origins near the right/bottom edge are clipped instead of wrapping onto the screen.
   logic [8:0] sum_x;
   logic [7:0] sum_y;
   assign sum_x     = {1'b0, ox} + 9'(xc);
   assign sum_y     = {1'b0, oy} + 8'(yc);
   assign pix_x     = sum_x[7:0];
   assign pix_y     = sum_y[6:0];
   assign in_screen = (sum_x < 9'(XSCREEN)) && (sum_y < 8'(YSCREEN));
`else
   assign pix_x     = ox + 8'(xc);
   assign pix_y     = oy + 7'(yc);
   assign in_screen = 1'b1;
`endif

   assign owner_oh   = NREQ'(1) << winner;
   assign grant      = (state == LATCH || state == DRAW) ? owner_oh : '0;
   assign done       = (state == DONE) ? owner_oh : '0;
   assign plot       = (state == DRAW) && in_screen;
   assign vga_x      = (state == DRAW) ? pix_x : hold_x;
   assign vga_y      = (state == DRAW) ? pix_y : hold_y;
   assign vga_colour = (state == DRAW) ? col   : hold_c;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: scenario tasks compare captured pixel streams and handshake timing against a box/round-robin model.
module tb_draw_arbiter;

   localparam int NREQ    = 4;
   localparam int XDIM    = 10;
   localparam int YDIM    = 10;
   localparam int XSCREEN = 160;
   localparam int YSCREEN = 120;
   localparam int NPIX    = XDIM * YDIM;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [8*NREQ-1:0] req_x = '0;
   logic [7*NREQ-1:0] req_y = '0;
   logic [3*NREQ-1:0] req_colour = '0;
   logic [NREQ-1:0]   grant, done;
   logic [7:0]        vga_x;
   logic [6:0]        vga_y;
   logic [2:0]        vga_colour;
   logic              plot, busy;

   int n_cmp = 0;
   int n_err = 0;
   int ptr_m = 0;
   int mx[NREQ], my[NREQ], mc[NREQ];
   int cap_x[$], cap_y[$], cap_c[$];
   int exp_x[$], exp_y[$], exp_c[$];
   int gcyc, gidx, dcyc, didx, multi, gbad, fplot, lplot, busy_after;

   draw_arbiter #(.NREQ(NREQ), .XDIM(XDIM), .YDIM(YDIM), .XSCREEN(XSCREEN), .YSCREEN(YSCREEN)) dut (
      .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
      .grant(grant), .done(done), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .plot(plot), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic set_req(input int i, input int x, input int y, input int c);
      req_x[8*i +: 8]      = x[7:0];
      req_y[7*i +: 7]      = y[6:0];
      req_colour[3*i +: 3] = c[2:0];
      mx[i] = x; my[i] = y; mc[i] = c;
      req[i] = 1'b1;
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
      for (int i = 0; i < NREQ; i++)
         if (m[(p + i) % NREQ]) return (p + i) % NREQ;
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   // Expected pixel stream of requester w's box, raster order, modulo-wrapped, optionally clipped.
   task automatic build_exp(input int w);
      int sx, sy;
      exp_x.delete(); exp_y.delete(); exp_c.delete();
      for (int yy = 0; yy < YDIM; yy++) begin
         for (int xx = 0; xx < XDIM; xx++) begin
            sx = mx[w] + xx;
            sy = my[w] + yy;
`ifdef DRAW_ARBITER_CLIP_EN
            if (sx >= XSCREEN || sy >= YSCREEN) continue;
`endif
            exp_x.push_back(sx % 256);
            exp_y.push_back(sy % 128);
            exp_c.push_back(mc[w]);
         end
      end
   endtask

   function automatic int pix_diff();
      int d;
      int n;
      d = 0;
      n = (cap_x.size() < exp_x.size()) ? cap_x.size() : exp_x.size();
      for (int i = 0; i < n; i++)
         if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_c[i] != exp_c[i]) d++;
      d += (cap_x.size() > exp_x.size()) ? cap_x.size() - exp_x.size() : exp_x.size() - cap_x.size();
      return d;
   endfunction

   // Records one box: cycle numbers are counted from the cycle the request is visible in IDLE.
   // rel: 0 keep req, 1 drop owner's req on done, 2 drop all on done.
   task automatic capture_box(input int rel, input int drop_pix, input int chg_cyc, input int chg_idx, input int chg_x);
      cap_x.delete(); cap_y.delete(); cap_c.delete();
      gcyc = -1; gidx = -1; dcyc = -1; didx = -1; multi = 0; gbad = 0;
      fplot = -1; lplot = -1; busy_after = -1;
      for (int n = 1; n <= 400 && dcyc < 0; n++) begin
         @(posedge clk); #1;
         if ($countones(grant) > 1) multi++;
         if (grant != '0 && gcyc < 0) begin
            gcyc = n;
            gidx = onehot_idx(grant);
         end
         if (gidx >= 0 && done == '0 && grant != (NREQ'(1) << gidx)) gbad++;
         if (plot) begin
            cap_x.push_back(int'(vga_x));
            cap_y.push_back(int'(vga_y));
            cap_c.push_back(int'(vga_colour));
            if (fplot < 0) fplot = n;
            lplot = n;
         end
         if (done != '0) begin
            dcyc = n;
            didx = onehot_idx(done);
            if (rel == 1) req[didx] = 1'b0;
            else if (rel == 2) req = '0;
         end
         if (drop_pix >= 0 && gidx >= 0 && cap_x.size() == drop_pix) req[gidx] = 1'b0;
         if (n == chg_cyc) req_x[8*chg_idx +: 8] = chg_x[7:0];
      end
      if (dcyc >= 0) begin
         @(posedge clk); #1;
         busy_after = int'(busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({grant, done, plot, vga_x, vga_y, vga_colour, busy} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got grant=%b done=%b plot=%b x=%0d y=%0d c=%0d busy=%b, required all 0",
                  grant, done, plot, vga_x, vga_y, vga_colour, busy);
      end
      rst = 1'b0;
      ptr_m = 0;
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0 || grant !== '0 || plot !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: got busy=%b grant=%b plot=%b with no req, required 0/0000/0", busy, grant, plot);
      end
   endtask

   task automatic test_single();
      set_req(0, 80, 30, 4);
      capture_box(1, -1, -1, 0, 0);
      build_exp(0);
      n_cmp++;
      if (gidx != 0 || gcyc != 1) begin
         n_err++;
         $display("FAIL single_grant: got owner %0d at cycle %0d, required owner 0 at cycle 1", gidx, gcyc);
      end
      n_cmp++;
      if (fplot != 2 || lplot != 1 + NPIX) begin
         n_err++;
         $display("FAIL single_plot_window: got first %0d last %0d, required 2 and %0d", fplot, lplot, 1 + NPIX);
      end
      n_cmp++;
      if (cap_x.size() != 100 || cap_x[0] != 80 || cap_y[0] != 30 || cap_x[10] != 80 || cap_y[10] != 31
          || cap_x[99] != 89 || cap_y[99] != 39 || pix_diff() != 0) begin
         n_err++;
         $display("FAIL single_pixels: got %0d plots with %0d differences from the box model, required 100 and 0",
                  cap_x.size(), pix_diff());
      end
      n_cmp++;
      if (dcyc != 2 + NPIX || didx != 0) begin
         n_err++;
         $display("FAIL single_done: got done[%0d] at cycle %0d, required done[0] at cycle %0d", didx, dcyc, 2 + NPIX);
      end
      n_cmp++;
      if (busy_after != 0 || multi != 0 || gbad != 0) begin
         n_err++;
         $display("FAIL single_busy_grant: got busy after done %0d, multi-grant %0d, grant glitches %0d, required 0/0/0",
                  busy_after, multi, gbad);
      end
      ptr_m = 1;
   endtask

   task automatic test_late_change();
      set_req(0, 80, 30, 5);
      capture_box(1, -1, 5, 0, 20);
      build_exp(0);
      n_cmp++;
      if (gidx != 0 || pix_diff() != 0) begin
         n_err++;
         $display("FAIL late_change_pixels: got owner %0d and %0d pixel differences, required owner 0 at origin 80 with 0",
                  gidx, pix_diff());
      end
      ptr_m = 1;
   endtask

   task automatic test_drop();
      set_req(2, 40, 50, 2);
      capture_box(1, 40, -1, 0, 0);
      build_exp(2);
      n_cmp++;
      if (gidx != 2 || cap_x.size() != 100 || pix_diff() != 0) begin
         n_err++;
         $display("FAIL drop_complete: got owner %0d with %0d plots (%0d diffs), required owner 2 with 100 (0)",
                  gidx, cap_x.size(), pix_diff());
      end
      n_cmp++;
      if (didx != 2 || dcyc != 2 + NPIX) begin
         n_err++;
         $display("FAIL drop_done: got done[%0d] at cycle %0d, required done[2] at cycle %0d", didx, dcyc, 2 + NPIX);
      end
      ptr_m = 3;
   endtask

   task automatic test_clip();
      set_req(3, 155, 115, 6);
      capture_box(1, -1, -1, 0, 0);
      build_exp(3);
      n_cmp++;
      if (cap_x.size() != exp_x.size() || pix_diff() != 0) begin
         n_err++;
         $display("FAIL clip_pixels: got %0d plots (%0d diffs), required %0d plots (0 diffs)",
                  cap_x.size(), pix_diff(), exp_x.size());
      end
      n_cmp++;
      if (gidx != 3 || didx != 3 || dcyc != 2 + NPIX) begin
         n_err++;
         $display("FAIL clip_done: got owner %0d done[%0d] at cycle %0d, required 3/3 at cycle %0d",
                  gidx, didx, dcyc, 2 + NPIX);
      end
      ptr_m = 0;
   endtask

   task automatic test_contention();
      logic [NREQ-1:0] m;
      int w;
      set_req(0, 10, 10, 1);
      set_req(1, 30, 20, 2);
      set_req(3, 50, 40, 3);
      m = req;
      for (int b = 0; b < 4; b++) begin
         w = rr_pick(m, ptr_m);
         capture_box((b == 3) ? 2 : 0, -1, -1, 0, 0);
         build_exp(w);
         n_cmp++;
         if (gidx != w || didx != w || gcyc != 1 || dcyc != 2 + NPIX) begin
            n_err++;
            $display("FAIL contention_order box %0d: got owner %0d done[%0d] grant@%0d done@%0d, required %0d at 1 and %0d",
                     b, gidx, didx, gcyc, dcyc, w, 2 + NPIX);
         end
         n_cmp++;
         if (cap_x.size() != NPIX || pix_diff() != 0 || multi != 0 || gbad != 0) begin
            n_err++;
            $display("FAIL contention_box %0d: got %0d plots, %0d diffs, %0d multi, %0d glitches, required %0d/0/0/0",
                     b, cap_x.size(), pix_diff(), multi, gbad, NPIX);
         end
         ptr_m = (w + 1) % NREQ;
      end
   endtask

   task automatic test_midreset();
      int cnt;
      bit seen_done;
      int w;
      set_req(1, 60, 70, 5);
      set_req(3, 100, 90, 7);
      cnt = 0;
      seen_done = 1'b0;
      for (int n = 1; n <= 300 && cnt < 50; n++) begin
         @(posedge clk); #1;
         if (plot) cnt++;
         if (done != '0) seen_done = 1'b1;
      end
      n_cmp++;
      if (cnt != 50) begin
         n_err++;
         $display("FAIL midreset_reach: got %0d plots before reset, required 50", cnt);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({grant, done, plot, vga_x, vga_y, vga_colour, busy} !== '0) begin
         n_err++;
         $display("FAIL midreset_outputs: got grant=%b done=%b plot=%b x=%0d y=%0d c=%0d busy=%b, required all 0",
                  grant, done, plot, vga_x, vga_y, vga_colour, busy);
      end
      repeat (2) begin
         @(posedge clk); #1;
         if (done != '0) seen_done = 1'b1;
      end
      n_cmp++;
      if (seen_done) begin
         n_err++;
         $display("FAIL midreset_no_done: got a done pulse for the abandoned box, required none");
      end
      rst = 1'b0;
      ptr_m = 0;
      for (int b = 0; b < 2; b++) begin
         w = rr_pick(req, ptr_m);
         capture_box(1, -1, -1, 0, 0);
         build_exp(w);
         n_cmp++;
         if (gidx != w || gcyc != 1 || didx != w || cap_x.size() != NPIX || pix_diff() != 0) begin
            n_err++;
            $display("FAIL midreset_regrant %0d: got owner %0d grant@%0d done[%0d] %0d plots %0d diffs, required %0d@1, %0d plots",
                     b, gidx, gcyc, didx, cap_x.size(), pix_diff(), w, NPIX);
         end
         ptr_m = (w + 1) % NREQ;
      end
   endtask

   task automatic test_random();
      logic [NREQ-1:0] m;
      int w;
      for (int r = 0; r < 6; r++) begin
         m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++)
            if (m[i]) set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
         for (int k = 0; k < NREQ && req != '0; k++) begin
            w = rr_pick(req, ptr_m);
            capture_box(1, -1, -1, 0, 0);
            build_exp(w);
            n_cmp++;
            if (gidx != w || didx != w || dcyc != 2 + NPIX || multi != 0) begin
               n_err++;
               $display("FAIL random_owner r%0d: got owner %0d done[%0d]@%0d multi %0d, required %0d done@%0d multi 0",
                        r, gidx, didx, dcyc, multi, w, 2 + NPIX);
            end
            n_cmp++;
            if (cap_x.size() != exp_x.size() || pix_diff() != 0) begin
               n_err++;
               $display("FAIL random_pixels r%0d: got %0d plots (%0d diffs), required %0d plots (0 diffs) for origin (%0d,%0d)",
                        r, cap_x.size(), pix_diff(), exp_x.size(), mx[w], my[w]);
            end
            ptr_m = (w + 1) % NREQ;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_late_change();
      test_drop();
      test_clip();
      test_contention();
      test_midreset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
